// File: rtl/alu_seq.sv
// Sequential ALU: registered result with valid/ready handshake; shifts iterate one bit per cycle.
// Define ALU_SEQ_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALU_Ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b1110;
  localparam logic [3:0] OP_SLL = 4'b1111;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_sra;
  logic             w_start_shift;

  assign w_accept   = valid_i && (r_state == S_IDLE);
  assign w_is_shift = (ALU_Ctrl_i == OP_SLL) || (ALU_Ctrl_i == OP_SRA);
  assign w_amt      = src2_i[SHW-1:0];

`ifdef ALU_SEQ_FAST_SHIFT_EN
  assign w_shl         = src1_i << w_amt;
  assign w_sra         = $unsigned($signed(src1_i) >>> w_amt);
  assign w_start_shift = 1'b0;
`else
  localparam logic [SHW-1:0] CNT_ONE = 1;

  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_work;
  logic             r_sra;
  logic [WIDTH-1:0] w_step;

  // A zero-amount shift is a pass-through and completes like any single-cycle op.
  assign w_shl         = src1_i;
  assign w_sra         = src1_i;
  assign w_start_shift = w_is_shift && (w_amt != '0);
  assign w_step        = r_sra ? {r_work[WIDTH-1], r_work[WIDTH-1:1]}
                               : {r_work[WIDTH-2:0], 1'b0};
`endif

  always_comb begin
    w_alu = src1_i + src2_i;
    case (ALU_Ctrl_i)
      OP_ADD: w_alu = src1_i + src2_i;
      OP_SUB: w_alu = src1_i - src2_i;
      OP_AND: w_alu = src1_i & src2_i;
      OP_OR:  w_alu = src1_i | src2_i;
      OP_XOR: w_alu = src1_i ^ src2_i;
      OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SLL: w_alu = w_shl;
      OP_SRA: w_alu = w_sra;
      default: w_alu = src1_i + src2_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_result <= '0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
      r_cnt    <= '0;
      r_work   <= '0;
      r_sra    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_start_shift) begin
              r_state <= S_SHIFT;
`ifndef ALU_SEQ_FAST_SHIFT_EN
              r_cnt   <= w_amt;
              r_work  <= src1_i;
              r_sra   <= (ALU_Ctrl_i == OP_SRA);
`endif
            end else begin
              r_state  <= S_DONE;
              r_result <= w_alu;
            end
          end
        end
`ifdef ALU_SEQ_FAST_SHIFT_EN
        S_SHIFT: r_state <= S_IDLE;
`else
        S_SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - CNT_ONE;
          // The last shift step lands directly in the visible result.
          if (r_cnt == CNT_ONE) begin
            r_result <= w_step;
            r_state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;
  assign zero_o   = (r_result == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected results, monitor pops on valid_o.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [3:0]   ALU_Ctrl_i = 4'b0010;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         valid_o;
  logic         ready_i = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALU_Ctrl_i(ALU_Ctrl_i), .src1_i(src1_i), .src2_i(src2_i),
    .result_o(result_o), .zero_o(zero_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  cyc;
  } exp_t;

  exp_t         q[$];
  int unsigned  cyc = 0;
  int unsigned  n_chk = 0;
  int unsigned  n_fail = 0;
  logic         auto_rdy = 1'b0;
  logic         man_rdy = 1'b0;
  logic         prev_v = 1'b0;
  logic [W-1:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) ready_i = auto_rdy ? 1'($urandom_range(0, 1)) : man_rdy;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned n;
    n = int'(b[4:0]);
    case (op)
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return a ^ b;
      4'b1110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111: return a << n;
      4'b1010: return a[W-1] ? ~((~a) >> n) : (a >> n);
      default: return a + b;
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'b1111 || op == 4'b1010) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready_o) begin
      chk("issue_ready_timeout", 32'(ready_o), 32'd1);
      return;
    end
    ALU_Ctrl_i = op;
    src1_i     = a;
    src2_i     = b;
    valid_i    = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    e.res = ref_alu(op, a, b);
    e.cyc = cyc + ref_lat(op, b) - 1;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      prev_v = 1'b0;
    end else begin
      if (valid_o && !prev_v) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(valid_o), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", result_o, e.res);
          chk("zero", 32'(zero_o), 32'(e.res == '0));
          chk("latency_cycle", cyc, e.cyc);
          held = result_o;
        end
      end else if (valid_o) begin
        chk("result_hold", result_o, held);
      end
      if (valid_o) chk("ready_low_in_done", 32'(ready_o), 32'd0);
      prev_v = valid_o;
    end
  end

  task automatic wait_drain();
    int unsigned w;
    w = 0;
    while ((q.size() != 0 || valid_o) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_result", result_o, '0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_zero", 32'(zero_o), 32'd1);
    rst_i = 1'b0;
    man_rdy = 1'b1;

    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1110, 32'h8000_0000, 32'd1);
    issue(4'b1110, 32'd1, 32'h8000_0000);
    issue(4'b1010, 32'h8000_0000, 32'h24);
    issue(4'b1111, 32'h1234_5678, 32'd0);
    issue(4'b0101, 32'h7000_0001, 32'h1000_0002);
    issue(4'b0110, 32'd3, 32'd5);
    issue(4'b1111, 32'h0000_0001, 32'd31);
    wait_drain();

    // Backpressure: result held while new requests are ignored.
    man_rdy = 1'b0;
    issue(4'b0111, 32'hA5A5_0000, 32'h0F0F_1234);
    begin
      int unsigned w;
      w = 0;
      while (!valid_o && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("bp_valid_seen", 32'(valid_o), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ALU_Ctrl_i = 4'($urandom_range(0, 15));
      src1_i     = $urandom;
      src2_i     = $urandom;
      valid_i    = 1'b1;
      chk("bp_ready_low", 32'(ready_o), 32'd0);
      chk("bp_valid_held", 32'(valid_o), 32'd1);
    end
    @(negedge clk);
    valid_i = 1'b0;
    man_rdy = 1'b1;
    begin
      int unsigned w;
      w = 0;
      while (!ready_o && w < 5) begin
        @(negedge clk);
        w++;
      end
      chk("bp_release_ready", 32'(ready_o), 32'd1);
      chk("bp_release_valid", 32'(valid_o), 32'd0);
    end

    // Reset mid-shift aborts without delivering a result.
    man_rdy = 1'b0;
    issue(4'b1111, 32'hDEAD_BEEF, 32'd31);
    repeat (10) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_result", result_o, '0);
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_zero", 32'(zero_o), 32'd1);
    q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    man_rdy = 1'b1;
    repeat (40) @(negedge clk);

    auto_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = b;
      issue(op, a, b);
    end
    wait_drain();
    auto_rdy = 1'b0;
    man_rdy = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
